// File: rtl/s_term_io_cfgmux.sv
// South-terminal I/O tile: NUM_IN south wires routed to NUM_OUT north wires through
// per-channel muxes configured over a serial daisy chain with atomic commit.

module clk_buf (
    input  logic clk_i,
    output logic clk_o
);
    assign clk_o = clk_i;
endmodule

module s_term_io_cfgmux #(
    parameter int NUM_IN   = 16,
    parameter int NUM_OUT  = 16,
    parameter int SEL_W    = $clog2(NUM_IN),
    parameter int CH_BITS  = SEL_W + 2,
    parameter int CFG_BITS = NUM_OUT * CH_BITS
) (
    input  logic               UserCLK,
    input  logic               ResetN,
    input  logic               MODE,
    input  logic               CONFin,
    output logic               CONFout,
    input  logic [NUM_IN-1:0]  S_END,
    output logic [NUM_OUT-1:0] N_BEG,
    output logic               UserCLKo,
    output logic               cfg_valid,
    output logic               cfg_err
);

    localparam int               CNT_W    = $clog2(CFG_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT,
        ABORT
    } state_e;

    state_e              state_q;
    logic [CFG_BITS-1:0] shadow_q;
    logic [CFG_BITS-1:0] active_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                confout_q;
    logic                cfg_valid_q;
    logic                cfg_err_q;

    logic [NUM_OUT-1:0]  raw;
    logic [NUM_OUT-1:0]  reg_en;
    logic [NUM_OUT-1:0]  chreg_d;
    logic [NUM_OUT-1:0]  chreg_q;
    logic                gate;

    // NOTE: the config registers are reset too, so a reset mid-load leaves no stale routing live.
    always_ff @(posedge UserCLK or negedge ResetN) begin
        if (!ResetN) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            active_q    <= '0;
            cnt_q       <= '0;
            confout_q   <= 1'b0;
            cfg_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            confout_q <= shadow_q[CFG_BITS-1];
            unique case (state_q)
                IDLE: begin
                    if (MODE) begin
                        shadow_q <= {shadow_q[CFG_BITS-2:0], CONFin};
                        cnt_q    <= CNT_W'(1);
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (MODE) begin
                        shadow_q <= {shadow_q[CFG_BITS-2:0], CONFin};
                        if (cnt_q != CNT_FULL) cnt_q <= cnt_q + 1'b1;
                    end else begin
                        state_q <= (cnt_q == CNT_FULL) ? COMMIT : ABORT;
                    end
                end
                COMMIT: begin
                    active_q    <= shadow_q;
                    cfg_valid_q <= 1'b1;
                    cfg_err_q   <= 1'b0;
                    state_q     <= IDLE;
                end
                ABORT: begin
                    cfg_err_q <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs are forced low while loading, during the commit/abort cycle, or before any commit.
    assign gate = MODE || (state_q == COMMIT) || (state_q == ABORT) || !cfg_valid_q;

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_ch
        logic [CH_BITS-1:0] field;
        logic [SEL_W-1:0]   sel;
        logic               in_bit;

        assign field     = active_q[k*CH_BITS +: CH_BITS];
        assign sel       = field[SEL_W-1:0];
        assign reg_en[k] = field[SEL_W];
        assign in_bit    = (int'(sel) < NUM_IN) ? S_END[sel] : 1'b0;
        assign raw[k]    = in_bit ^ field[SEL_W+1];
    end

    assign chreg_d = gate ? '0 : raw;

    always_ff @(posedge UserCLK or negedge ResetN) begin
        if (!ResetN) chreg_q <= '0;
        else         chreg_q <= chreg_d;
    end

    assign N_BEG     = gate ? '0 : ((reg_en & chreg_q) | (~reg_en & raw));
    assign CONFout   = confout_q;
    assign cfg_valid = cfg_valid_q;
    assign cfg_err   = cfg_err_q;

    clk_buf u_clk_buf (
        .clk_i (UserCLK),
        .clk_o (UserCLKo)
    );

endmodule

// File: tb/tb_s_term_io_cfgmux.sv
// Directed self-checking bench for s_term_io_cfgmux: reset, routing, register/invert,
// abort handling, daisy-chain pass-through and asynchronous reset mid-load.

module tb_s_term_io_cfgmux;

    localparam int CFG_BITS = 96;

    logic        user_clk = 1'b0;
    logic        reset_n;
    logic        mode;
    logic        conf_in;
    logic        conf_out;
    logic [15:0] s_end;
    logic [15:0] n_beg;
    logic        user_clk_o;
    logic        cfg_valid;
    logic        cfg_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [95:0] cfg_a, cfg_b, p1, p2, cap;

    s_term_io_cfgmux dut (
        .UserCLK   (user_clk),
        .ResetN    (reset_n),
        .MODE      (mode),
        .CONFin    (conf_in),
        .CONFout   (conf_out),
        .S_END     (s_end),
        .N_BEG     (n_beg),
        .UserCLKo  (user_clk_o),
        .cfg_valid (cfg_valid),
        .cfg_err   (cfg_err)
    );

    always #5 user_clk = ~user_clk;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    function automatic logic [95:0] set_ch(input logic [95:0] cfg, input int k,
                                           input logic inv, input logic rg, input logic [3:0] sel);
        logic [95:0] c;
        c = cfg;
        c[k*6 +: 6] = {inv, rg, sel};
        return c;
    endfunction

    // Shifts v[n-1] first; returns with MODE already dropped. For n > 96 the CONFout
    // stream seen after bit 96 is captured into co_cap (MSB first).
    task automatic load(input logic [191:0] v, input int n, output logic [95:0] co_cap);
        co_cap = '0;
        for (int j = 0; j < n; j++) begin
            mode    = 1'b1;
            conf_in = v[n-1-j];
            tick();
            if (j >= CFG_BITS) co_cap[2*CFG_BITS-1-j] = conf_out;
        end
        mode    = 1'b0;
        conf_in = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        mode    = 1'b0;
        conf_in = 1'b0;
        s_end   = '0;
        repeat (3) @(posedge user_clk);
        #1 reset_n = 1'b1;
        tick();

        check("rst_nbeg",    n_beg,     16'h0000);
        check("rst_confout", conf_out,  1'b0);
        check("rst_valid",   cfg_valid, 1'b0);
        check("rst_err",     cfg_err,   1'b0);
        s_end = 16'hFFFF; #1;
        check("rst_nbeg_ffff", n_beg, 16'h0000);
        tick();
        s_end = 16'hA5A5; #1;
        check("rst_nbeg_a5a5", n_beg, 16'h0000);
        #1;
        check("clk_fwd", user_clk_o, user_clk);

        // Channel 0 selects S_END[5]; every other channel selects S_END[0].
        cfg_a = set_ch('0, 0, 1'b0, 1'b0, 4'd5);
        s_end = '0;
        load({96'b0, cfg_a}, 96, cap);
        tick();
        check("valid_1cyc", cfg_valid, 1'b0);
        tick();
        check("valid_2cyc", cfg_valid, 1'b1);
        check("err_after_a", cfg_err, 1'b0);
        s_end = 16'h0020; #1;
        check("a_0020", n_beg, 16'h0001);
        s_end = 16'h0021; #1;
        check("a_0021", n_beg, 16'hFFFF);
        s_end = 16'h0001; #1;
        check("a_0001", n_beg, 16'hFFFE);

        // Add channel 3 = inverted, registered, SEL=15.
        cfg_b   = set_ch(cfg_a, 3, 1'b1, 1'b1, 4'd15);
        s_end   = 16'hFFFF;
        mode    = 1'b1;
        conf_in = cfg_b[95];
        #1;
        check("gate_mode", n_beg, 16'h0000);
        load({96'b0, cfg_b}, 96, cap);
        s_end = 16'h0021;
        tick();
        check("gate_commit", n_beg, 16'h0000);
        tick();
        check("b_first_idle", n_beg, 16'hFFF7);
        tick();
        check("b_reg_lat", n_beg, 16'hFFFF);
        s_end = 16'h8000; #1;
        check("b_s15_hold", n_beg, 16'h0008);
        tick();
        check("b_s15_inv", n_beg, 16'h0000);
        s_end = 16'h0000; #1;
        check("b_s0_hold", n_beg, 16'h0000);
        tick();
        check("b_s0_inv", n_beg, 16'h0008);

        // Short load of 40 ones must abort and leave cfg_b live.
        load({192{1'b1}}, 40, cap);
        tick();
        tick();
        check("abort_err",   cfg_err,   1'b1);
        check("abort_valid", cfg_valid, 1'b1);
        s_end = 16'h0020;
        tick();
        check("abort_keep", n_beg, 16'h0009);

        load({96'b0, cfg_a}, 96, cap);
        tick();
        tick();
        check("reload_err", cfg_err, 1'b0);
        s_end = 16'h0020; #1;
        check("reload_route", n_beg, 16'h0001);

        // One-cycle MODE pulse counts one bit and aborts.
        mode = 1'b1;
        tick();
        mode = 1'b0;
        tick();
        tick();
        check("pulse_err", cfg_err, 1'b1);
        check("pulse_route", n_beg, 16'h0001);

        // 192 bits: second half is a bit-reversal routing with channel 7 inverted.
        p1 = 96'hDEADBEEF_CAFEF00D_12345678;
        p2 = '0;
        for (int k = 0; k < 16; k++) p2 = set_ch(p2, k, k == 7, 1'b0, 4'(15 - k));
        load({p1, p2}, 192, cap);
        check("confout_delay", cap, p1);
        tick();
        tick();
        check("p2_err", cfg_err, 1'b0);
        s_end = 16'h0001; #1;
        check("p2_0001", n_beg, 16'h8080);
        s_end = 16'h0100; #1;
        check("p2_0100", n_beg, 16'h0000);
        s_end = 16'h00FF; #1;
        check("p2_00ff", n_beg, 16'hFF80);

        // Asynchronous reset in the middle of a load.
        s_end = 16'hFFFF;
        for (int j = 0; j < 50; j++) begin
            mode    = 1'b1;
            conf_in = j[0];
            tick();
        end
        check("pre_rst_valid", cfg_valid, 1'b1);
        #2;
        mode    = 1'b0;
        reset_n = 1'b0;
        #1;
        check("arst_nbeg",    n_beg,     16'h0000);
        check("arst_confout", conf_out,  1'b0);
        check("arst_valid",   cfg_valid, 1'b0);
        check("arst_err",     cfg_err,   1'b0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_valid", cfg_valid, 1'b0);
        check("post_rst_nbeg",  n_beg,     16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running, expected done");
        $fatal(1);
    end

endmodule
